zero_cross_detector: RTL and testbench
======================================

// Module: zero_cross_detector
// PURPOSE
//  Front-end stage between audio_codec (left ADC channel) and the tuner frequency counter.
//  Pulls samples over the codec read_ready/read handshake and applies a signed hysteresis
//  comparator. Emits a one-cycle pulse on each validated rising zero crossing, plus the
//  period in samples since the previous crossing.
//  Downstream blocks count cross_pulse or consume period directly.
// PARAMETERS
//  SAMPLE_W    24     codec sample width, two's complement
//  HYST        4096   hysteresis half-band; sample >= +HYST is POS, sample <= -HYST is NEG
//  PERIOD_W    16     width of period counter/output
//  MIN_PERIOD  8      crossings closer than this many samples are rejected as glitches
//  TIMEOUT     48000  samples without a valid crossing before no_signal (1 s at 48 kHz)
// PORTS
//  clock         in   1         system clock (CLOCK_50 domain, same as audio_codec)
//  resetn        in   1         reset, asynchronous, active-low
//  enable        in   1         1 = run; 0 = idle, counters cleared
//  read_ready    in   1         codec has a new sample pair
//  read          out  1         accept strobe to codec
//  sample_in     in   SAMPLE_W  codec readdata_left
//  cross_pulse   out  1         1-cycle pulse per validated rising crossing
//  period_valid  out  1         1-cycle pulse; period holds a new measurement
//  period        out  PERIOD_W  samples between last two validated crossings (held)
//  no_signal     out  1         level; set on timeout, cleared on next validated crossing
// BEHAVIOUR
//  Reset (resetn=0, async)
//   - read=0, cross_pulse=0, period_valid=0, period=0, no_signal=0.
//   - State is IDLE and the sample counter is 0.
//  Handshake
//   - read = enable & read_ready (combinational).
//   - A sample is accepted at any clock edge where read=1. It is captured in sample_q.
//   - No backpressure: one accept per edge is legal.
//  Classification
//   - Uses the registered sample_q on the cycle after the accept. All compares are signed.
//  Latency
//   - For a sample accepted at edge E, cross_pulse and period_valid are high during the
//     cycle after edge E+1.
//  FSM states: IDLE, UNKNOWN, NEG, POS
//   - IDLE    -> UNKNOWN when enable=1. Any state -> IDLE when enable=0; counter cleared.
//     no_signal and period are held.
//   - UNKNOWN -> NEG when sample <= -HYST. UNKNOWN -> POS when sample >= +HYST.
//     No crossing is reported from UNKNOWN.
//   - NEG     -> POS when sample >= +HYST. This is a rising crossing event.
//   - POS     -> NEG when sample <= -HYST. No event.
//   - A sample inside the band (-HYST, +HYST) leaves the state unchanged.
//  Sample counter
//   - Increments once per accepted sample. Saturates at 2^PERIOD_W-1 (no wrap).
//  Rising crossing event
//   - count includes the crossing sample.
//   - First event after UNKNOWN: counter cleared to 0, no pulses.
//   - Otherwise, if count >= MIN_PERIOD: period<=count, cross_pulse=1, period_valid=1,
//     no_signal<=0, counter cleared.
//   - Otherwise the event is a glitch: state still goes POS, counter keeps running,
//     no pulses.
//  Timeout
//   - When count reaches TIMEOUT: no_signal<=1, state<=UNKNOWN, counter cleared.
//   - If timeout and a crossing occur on the same sample, the crossing wins.
//  Reset mid-operation
//   - Immediate async return to reset values. Any in-flight sample is discarded.
// STRUCTURE
//  Shared package tuner_pkg holds:
//   - state encoding localparams: ST_IDLE=2'd0, ST_UNKNOWN=2'd1, ST_NEG=2'd2, ST_POS=2'd3
//   - constants: SAMPLE_RATE=48000, default HYST
//  One sub-module: hyst_compare, combinational. Maps (sample_q, HYST) to {is_pos, is_neg}.
//  FSM, counter and output registers stay in zero_cross_detector.
// TESTING
//  1. Square wave +/-100000, 24 samples high / 24 low, read_ready every 4 clocks
//     -> first crossing silent; afterwards period=48 and one cross_pulse per 48 samples.
//  2. Wave +/-1000 (inside band) for 1000 samples
//     -> no cross_pulse, no period_valid, state remains UNKNOWN.
//  3. Valid wave with a 3-sample dip to -5000 then +5000 injected
//     -> glitch rejected; the next valid period reports the full count (e.g. 48 + 0 error).
//  4. Constant 0 for 48000 samples after a valid wave -> no_signal=1 at sample 48000;
//     a subsequent 48-sample wave clears it on the second crossing.
//  5. resetn pulsed low between samples mid-wave
//     -> all outputs 0 immediately; the first crossing after release is silent.
//  6. enable dropped in the same cycle as read_ready=1
//     -> read=0, sample not accepted, state IDLE, period held.

Source files
------------

// File: rtl/tuner_pkg.sv
// Shared tuner constants and the zero-cross FSM state encoding.
// Imported by the detector and its hysteresis comparator.
package tuner_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_UNKNOWN = 2'd1;
    localparam logic [1:0] ST_NEG     = 2'd2;
    localparam logic [1:0] ST_POS     = 2'd3;

    localparam int SAMPLE_RATE = 48000;
    localparam int HYST_DEF    = 4096;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        UNKNOWN = ST_UNKNOWN,
        NEG     = ST_NEG,
        POS     = ST_POS
    } zc_state_e;

endpackage

// File: rtl/hyst_compare.sv
// Signed hysteresis comparator: classifies one sample as
// above +HYST, below -HYST, or inside the dead band.
module hyst_compare
    import tuner_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int HYST     = HYST_DEF
) (
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic                o_is_pos,
    output logic                o_is_neg
);

    localparam logic signed [SAMPLE_W-1:0] HYST_P = SAMPLE_W'(HYST);
    localparam logic signed [SAMPLE_W-1:0] HYST_N = -HYST_P;

    logic signed [SAMPLE_W-1:0] w_s;

    assign w_s      = $signed(i_sample);
    assign o_is_pos = (w_s >= HYST_P);
    assign o_is_neg = (w_s <= HYST_N);

endmodule

// File: rtl/zero_cross_detector.sv
// Rising zero-cross detector with hysteresis, glitch rejection,
// period measurement and loss-of-signal timeout.
module zero_cross_detector
    import tuner_pkg::*;
#(
    parameter int SAMPLE_W   = 24,
    parameter int HYST       = HYST_DEF,
    parameter int PERIOD_W   = 16,
    parameter int MIN_PERIOD = 8,
    parameter int TIMEOUT    = SAMPLE_RATE
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                enable,
    input  logic                read_ready,
    output logic                read,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                cross_pulse,
    output logic                period_valid,
    output logic [PERIOD_W-1:0] period,
    output logic                no_signal
);

    localparam logic [PERIOD_W-1:0] CNT_MIN = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] CNT_TMO = PERIOD_W'(TIMEOUT);

    zc_state_e           r_state;
    zc_state_e           w_state_nx;
    logic [SAMPLE_W-1:0] r_sample_q;
    logic                r_vld;
    logic [PERIOD_W-1:0] r_count;
    logic [PERIOD_W-1:0] w_count_nx;
    logic [PERIOD_W-1:0] w_cnt_inc;
    logic                r_first;
    logic                w_first_nx;
    logic                r_cross;
    logic                w_cross_nx;
    logic                r_pv;
    logic                w_pv_nx;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] w_period_nx;
    logic                r_no_sig;
    logic                w_no_sig_nx;
    logic                w_is_pos;
    logic                w_is_neg;
    logic                w_rise;

    assign read         = enable & read_ready;
    assign cross_pulse  = r_cross;
    assign period_valid = r_pv;
    assign period       = r_period;
    assign no_signal    = r_no_sig;

    hyst_compare #(
        .SAMPLE_W (SAMPLE_W),
        .HYST     (HYST)
    ) u_cmp (
        .i_sample (r_sample_q),
        .o_is_pos (w_is_pos),
        .o_is_neg (w_is_neg)
    );

    // Counter saturates so a long silence never wraps into a fake period
    assign w_cnt_inc = (r_count == '1) ? r_count : r_count + 1'b1;
    assign w_rise    = (r_state == NEG) & w_is_pos;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sample_q <= '0;
            r_vld      <= 1'b0;
        end else begin
            r_vld <= read;
            if (read) begin
                r_sample_q <= sample_in;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_first  <= 1'b1;
            r_cross  <= 1'b0;
            r_pv     <= 1'b0;
            r_period <= '0;
            r_no_sig <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_count  <= w_count_nx;
            r_first  <= w_first_nx;
            r_cross  <= w_cross_nx;
            r_pv     <= w_pv_nx;
            r_period <= w_period_nx;
            r_no_sig <= w_no_sig_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_first_nx  = r_first;
        w_cross_nx  = 1'b0;
        w_pv_nx     = 1'b0;
        w_period_nx = r_period;
        w_no_sig_nx = r_no_sig;
        if (!enable) begin
            w_state_nx = IDLE;
            w_count_nx = '0;
        end else if (r_state == IDLE) begin
            w_state_nx = UNKNOWN;
            w_first_nx = 1'b1;
            w_count_nx = '0;
        end else if (r_vld) begin
            w_count_nx = w_cnt_inc;
            if (w_rise) begin
                w_state_nx = POS;
                if (r_first) begin
                    w_first_nx = 1'b0;
                    w_count_nx = '0;
                end else if (w_cnt_inc >= CNT_MIN) begin
                    w_period_nx = w_cnt_inc;
                    w_cross_nx  = 1'b1;
                    w_pv_nx     = 1'b1;
                    w_no_sig_nx = 1'b0;
                    w_count_nx  = '0;
                end
            end else if (w_cnt_inc == CNT_TMO) begin
                // Silence: rearm so the next crossing starts a fresh measurement
                w_state_nx  = UNKNOWN;
                w_first_nx  = 1'b1;
                w_count_nx  = '0;
                w_no_sig_nx = 1'b1;
            end else begin
                unique case (1'b1)
                    w_is_pos: w_state_nx = POS;
                    w_is_neg: w_state_nx = NEG;
                    default:  w_state_nx = r_state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zero_cross_detector.sv
// Randomized bench for zero_cross_detector against a sample-level
// behavioural model of crossings, periods and timeout.
module tb_zero_cross_detector;

    localparam int HYST = 4096;
    localparam int MINP = 8;
    localparam int TMO  = 48000;
    localparam int CMAX = 65535;

    logic        clock = 1'b0;
    logic        resetn;
    logic        enable;
    logic        read_ready;
    logic        read;
    logic [23:0] sample_in;
    logic        cross_pulse;
    logic        period_valid;
    logic [15:0] period;
    logic        no_signal;

    int n_chk  = 0;
    int n_fail = 0;

    int m_pol;
    int m_cnt;
    int m_per;
    int m_ps;
    bit m_seen;
    bit m_ns;
    bit m_cp;
    bit m_pv;
    bit m_pend;

    always #5 clock = ~clock;

    zero_cross_detector dut (
        .clock        (clock),
        .resetn       (resetn),
        .enable       (enable),
        .read_ready   (read_ready),
        .read         (read),
        .sample_in    (sample_in),
        .cross_pulse  (cross_pulse),
        .period_valid (period_valid),
        .period       (period),
        .no_signal    (no_signal)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s got=%0d exp=%0d t=%0t",
                         tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pol  = 0;
        m_cnt  = 0;
        m_per  = 0;
        m_ps   = 0;
        m_seen = 0;
        m_ns   = 0;
        m_cp   = 0;
        m_pv   = 0;
        m_pend = 0;
    endtask

    // One processed sample: polarity -1/0/+1, counting since last crossing
    task automatic m_sample(input int s);
        int c;
        c = (s >= HYST) ? 1 : ((s <= -HYST) ? -1 : 0);
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (m_pol == -1 && c == 1) begin
            m_pol = 1;
            if (!m_seen) begin
                m_seen = 1;
                m_cnt  = 0;
            end else if (m_cnt >= MINP) begin
                m_cp  = 1;
                m_pv  = 1;
                m_per = m_cnt;
                m_ns  = 0;
                m_cnt = 0;
            end
        end else if (m_cnt == TMO) begin
            m_ns   = 1;
            m_pol  = 0;
            m_seen = 0;
            m_cnt  = 0;
        end else if (c != 0) begin
            m_pol = c;
        end
    endtask

    task automatic m_edge();
        m_cp = 0;
        m_pv = 0;
        if (!enable) begin
            m_pol  = 0;
            m_seen = 0;
            m_cnt  = 0;
            m_pend = 0;
        end else begin
            if (m_pend) m_sample(m_ps);
            m_pend = read_ready;
            m_ps   = int'($signed(sample_in));
        end
    endtask

    task automatic check_outs();
        chk("read", 32'(read), 32'(enable & read_ready));
        chk("cross_pulse", 32'(cross_pulse), 32'(m_cp));
        chk("period_valid", 32'(period_valid), 32'(m_pv));
        chk("period", 32'(period), 32'(m_per));
        chk("no_signal", 32'(no_signal), 32'(m_ns));
    endtask

    task automatic step(input bit en, input bit rr, input int s);
        @(negedge clock);
        enable     = en;
        read_ready = rr;
        sample_in  = s[23:0];
        @(posedge clock);
        m_edge();
        #1;
        check_outs();
    endtask

    task automatic feed(input int s, input int gap);
        step(1'b1, 1'b1, s);
        repeat (gap) step(1'b1, 1'b0, int'($urandom));
    endtask

    task automatic square(input int amp, input int half, input int nper,
                          input int gap, input bit rnd);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < 2 * half; i++) begin
                feed((i < half) ? -amp : amp,
                     rnd ? int'($urandom_range(0, gap)) : gap);
            end
        end
    endtask

    task automatic glitch_wave(input int nper);
        int seq[$];
        for (int p = 0; p < nper; p++) begin
            seq = {};
            repeat (24) seq.push_back(-100000);
            seq.push_back(100000);
            repeat (3) seq.push_back(-5000);
            seq.push_back(5000);
            repeat (19) seq.push_back(100000);
            foreach (seq[k]) feed(seq[k], int'($urandom_range(0, 2)));
        end
    endtask

    // Reset pulse entirely between two clock edges
    task automatic pulse_reset();
        #1;
        resetn     = 1'b0;
        read_ready = 1'b0;
        #1;
        m_reset();
        check_outs();
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        int amp;
        resetn     = 1'b0;
        enable     = 1'b0;
        read_ready = 1'b0;
        sample_in  = '0;
        m_reset();
        #2;
        check_outs();
        #5;
        resetn = 1'b1;

        square(100000, 24, 5, 3, 1'b0);

        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < 1000; i++)
            feed(((i / 24) % 2 == 0) ? -1000 : 1000, 0);
        square(100000, 24, 3, 0, 1'b0);

        glitch_wave(3);

        for (int i = 0; i < TMO + 10; i++) feed(0, 0);
        square(100000, 24, 3, 0, 1'b0);

        square(100000, 24, 2, 1, 1'b0);
        repeat (10) feed(-100000, 0);
        pulse_reset();
        repeat (14) feed(-100000, 0);
        square(100000, 24, 3, 1, 1'b0);

        repeat (5) feed(100000, 0);
        step(1'b0, 1'b1, -100000);
        step(1'b0, 1'b1, 100000);
        square(100000, 24, 3, 0, 1'b0);

        square(100000, 4, 4, 0, 1'b0);
        square(100000, 3, 6, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 3) == 0)
                amp = 4095 + int'($urandom_range(0, 1));
            else
                amp = int'($urandom_range(HYST, 4000000));
            square(amp, int'($urandom_range(2, 30)), 2,
                   int'($urandom_range(0, 3)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
